rr_grant_arbiter: RTL

Round-robin arbiter that produces the registered one-hot select vector consumed by the downstream one-hot mux, for example for CDB or functional-unit result selection.
- Takes per-source requests and lock (multi-beat) hints.
- Issues one grant at a time and holds it stable until the consumer accepts it.
- Rotates priority after every completed transfer, so no source starves.

---
 rtl/rr_grant_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter producing a registered one-hot select
// for a downstream one-hot mux. A grant is held until ready accepts it. Priority
// rotates past the served source after every completed transfer. A lock hint
// from the granted source keeps the grant across beats.
//
// Optional build macro RR_ARB_STARVE_WDOG_EN adds a per-source starvation
// watchdog with a sticky starve_err output (parameter STARVE_LIMIT).
module rr_grant_arbiter #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
`ifdef RR_ARB_STARVE_WDOG_EN
    ,
    parameter int STARVE_LIMIT = 64
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] lock,
    input  logic             ready,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
`ifdef RR_ARB_STARVE_WDOG_EN
    ,
    output logic             starve_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_HOT_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WIDTH-1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;

    logic [IDX_W-1:0] ptr_adv;
    logic [IDX_W:0]   pick_idle;
    logic [IDX_W:0]   pick_next;

    // Returns {found, index} of the first set bit of r scanning upward from p
    // with wrap-around. Scanning from the far end lets the closest hit win.
    function automatic logic [IDX_W:0] rr_pick(input logic [WIDTH-1:0] r,
                                               input logic [IDX_W-1:0] p);
        logic [IDX_W:0] res;
        int             pos;
        res = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            pos = int'(p) + k;
            if (pos >= WIDTH) begin
                pos = pos - WIDTH;
            end
            if (r[pos]) begin
                res = {1'b1, IDX_W'(pos)};
            end
        end
        return res;
    endfunction

    // Pointer one past the current grant, wrapping at the last source.
    assign ptr_adv   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    // Fresh arbitration from idle, and the back-to-back decision on completion
    // with the just-served source masked out.
    assign pick_idle = rr_pick(req, ptr_reg);
    assign pick_next = rr_pick(req & ~grant_reg, ptr_adv);

    // State register: FSM state, held grant, its index and the priority pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next-state logic: grant from idle, hold while waiting, continue a burst or
    // rotate and re-arbitrate once the consumer accepts.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_idle[IDX_W]) begin
                    state_next = GRANT;
                    idx_next   = pick_idle[IDX_W-1:0];
                    grant_next = ONE_HOT_LSB << pick_idle[IDX_W-1:0];
                end
            end
            GRANT, LOCKED: begin
                if (ready) begin
                    if (lock[idx_reg] && req[idx_reg]) begin
                        state_next = LOCKED;
                    end else begin
                        ptr_next = ptr_adv;
                        if (pick_next[IDX_W]) begin
                            state_next = GRANT;
                            idx_next   = pick_next[IDX_W-1:0];
                            grant_next = ONE_HOT_LSB << pick_next[IDX_W-1:0];
                        end else begin
                            state_next = IDLE;
                            idx_next   = '0;
                            grant_next = '0;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                grant_next = '0;
            end
        endcase
    end

    // Outputs come straight from registers; no combinational path from req.
    always_comb begin
        grant       = grant_reg;
        grant_valid = |grant_reg;
        grant_idx   = idx_reg;
    end

`ifdef RR_ARB_STARVE_WDOG_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [WIDTH-1:0] starve_hit;
    logic             starve_err_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_wdog
        logic [CNT_W-1:0] cnt_reg;
        logic             starving;

        assign starving = req[gi] && !grant_reg[gi];
        // Flags the edge at which this counter reaches the limit.
        assign starve_hit[gi] = starving && (cnt_reg >= CNT_MAX - 1'b1);

        // Saturating count of consecutive cycles spent requesting without grant.
        always_ff @(posedge clock) begin
            if (!reset) begin
                cnt_reg <= '0;
            end else if (starving) begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // Sticky error: once any source starves to the limit it stays set until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_err_reg <= 1'b0;
        end else if (|starve_hit) begin
            starve_err_reg <= 1'b1;
        end
    end

    assign starve_err = starve_err_reg;
`endif

endmodule
